ascon_round_sequencer: RTL and testbench
========================================

ASCON_ROUND_SEQUENCER -- requirements
Module: ascon_round_sequencer

Interface
REQ-001 Parameter PA_ROUNDS, default 12, rounds in initialization and finalization permutations.
REQ-002 Parameter PB_ROUNDS, default 8, rounds in each intermediate data-block permutation.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  request new operation; sampled only in IDLE.
REQ-006 operation_mode  in  3  0=encrypt, 1=decrypt, others illegal.
REQ-007 num_ad_blocks  in  4  associated-data block count, 0..15; 0 = no AD.
REQ-008 num_msg_blocks  in  4  message block count incl. padded final block, 1..15; 0 illegal.
REQ-009 abort  in  1  cancel operation in progress.
REQ-010 blk_ack  in  1  datapath has a 128-bit block ready for the current request.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 done  out  1  one-cycle pulse on successful completion.
REQ-013 err  out  1  one-cycle pulse on illegal start parameters.
REQ-014 decrypt  out  1  latched mode bit for the datapath; valid while busy.
REQ-015 state_load  out  1  load IV/key/nonce into the state registers.
REQ-016 perm_en  out  1  apply one permutation round this cycle.
REQ-017 round_idx  out  4  round-constant index for the current round.
REQ-018 key_xor  out  1  XOR key into state (init/final tail, final head).
REQ-019 blk_req  out  1  requesting a data block.
REQ-020 blk_sel  out  1  0=AD block, 1=message block; valid while blk_req high.
REQ-021 absorb_en  out  1  equals blk_req AND blk_ack; absorb block this cycle.
REQ-022 last_blk  out  1  high with blk_req when the requested block is the last of its kind.
REQ-023 dom_sep  out  1  apply domain-separation bit.
REQ-024 tag_en  out  1  capture tag from state this cycle.

Function
REQ-025 States SHALL be IDLE, LOAD, INIT_P, INIT_K, AD_WAIT, AD_P, DSEP, MSG_WAIT, MSG_P, FIN_K, FIN_P, TAG, DONE.
REQ-026 IDLE + start + legal params -> LOAD; mode, block counts latched on that edge.
REQ-027 IDLE + start + illegal mode or num_msg_blocks=0 -> err pulse next cycle, remain IDLE, no other output asserts.
REQ-028 LOAD: state_load for exactly 1 cycle -> INIT_P.
REQ-029 INIT_P/FIN_P: perm_en for PA_ROUNDS cycles, round_idx = 12-PA_ROUNDS .. 11, incrementing by 1 per cycle.
REQ-030 AD_P/MSG_P: perm_en for PB_ROUNDS cycles, round_idx = 12-PB_ROUNDS .. 11.
REQ-031 INIT_P done -> INIT_K (key_xor 1 cycle) -> AD_WAIT if num_ad_blocks>0, else DSEP.
REQ-032 AD_WAIT: blk_req=1, blk_sel=0; waits indefinitely; on blk_ack -> AD_P; AD_P done -> AD_WAIT if AD blocks remain, else DSEP.
REQ-033 DSEP: dom_sep 1 cycle -> MSG_WAIT.
REQ-034 MSG_WAIT: blk_req=1, blk_sel=1; on blk_ack -> MSG_P if not last block, else FIN_K.
REQ-035 FIN_K: key_xor 1 cycle -> FIN_P -> TAG (tag_en and key_xor 1 cycle) -> DONE (done 1 cycle) -> IDLE.
REQ-036 Block counters SHALL decrement on absorb_en only; last_blk = remaining count equals 1.
REQ-037 blk_ack outside AD_WAIT/MSG_WAIT SHALL be ignored.
REQ-038 start while busy SHALL be ignored.
REQ-039 abort in any non-IDLE state -> IDLE next cycle, all strobes low, no done; abort in IDLE ignored.
REQ-040 abort and blk_ack same cycle: abort wins; absorb_en still reflects combinational AND that cycle.
REQ-041 perm_en, state_load, key_xor, dom_sep, tag_en, blk_req SHALL be mutually exclusive except key_xor with tag_en in TAG.

Reset
REQ-042 rst high -> IDLE next edge; all outputs 0, counters 0, round_idx 0; mid-operation reset same, no done.

Verification
REQ-043 Encrypt, 0 AD, 1 msg, blk_ack held high: start at edge 0 -> done high in cycle 31, 24 perm_en cycles total, err never.
REQ-044 Decrypt, 2 AD, 3 msg, blk_ack delayed 5 cycles per request: 5 absorb_en pulses, 4 PB bursts round_idx 4..11, decrypt=1, last_blk on 2nd AD and 3rd msg.
REQ-045 start with operation_mode=5, then num_msg_blocks=0: err pulse each, busy stays 0.
REQ-046 abort during AD_P round 3: IDLE next cycle, no done; new start then completes normally.
REQ-047 rst asserted in FIN_P: all outputs 0 next cycle; start pulse while busy ignored.
REQ-048 PA_ROUNDS=6, PB_ROUNDS=6: INIT_P round_idx 6..11, AD_P 6..11.

Source files
------------

// File: rtl/ascon_round_sequencer.sv
// Control sequencer for an Ascon AEAD datapath: walks init, AD absorb, message
// absorb and finalization, issuing one permutation round per cycle.
module ascon_round_sequencer #(
  parameter int PA_ROUNDS = 12,
  parameter int PB_ROUNDS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] operation_mode,
  input  logic [3:0] num_ad_blocks,
  input  logic [3:0] num_msg_blocks,
  input  logic       abort,
  input  logic       blk_ack,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       decrypt,
  output logic       state_load,
  output logic       perm_en,
  output logic [3:0] round_idx,
  output logic       key_xor,
  output logic       blk_req,
  output logic       blk_sel,
  output logic       absorb_en,
  output logic       last_blk,
  output logic       dom_sep,
  output logic       tag_en
);

  typedef enum logic [3:0] {
    IDLE, LOAD, INIT_P, INIT_K, AD_WAIT, AD_P, DSEP,
    MSG_WAIT, MSG_P, FIN_K, FIN_P, TAG, DONE
  } state_t;

  // Reduced-round permutations use the tail of the 12-entry constant table.
  localparam logic [3:0] PA_FIRST   = 4'(12 - PA_ROUNDS);
  localparam logic [3:0] PB_FIRST   = 4'(12 - PB_ROUNDS);
  localparam logic [3:0] LAST_ROUND = 4'd11;

  state_t     state;
  state_t     state_n;
  logic [3:0] ad_cnt;
  logic [3:0] ad_cnt_n;
  logic [3:0] msg_cnt;
  logic [3:0] msg_cnt_n;
  logic [3:0] round_n;
  logic       decrypt_n;
  logic       err_n;
  logic       legal;

  assign legal     = (operation_mode <= 3'd1) && (num_msg_blocks != 4'd0);
  assign absorb_en = blk_req & blk_ack;

  always_comb begin
    state_n   = state;
    ad_cnt_n  = ad_cnt;
    msg_cnt_n = msg_cnt;
    round_n   = round_idx;
    decrypt_n = decrypt;
    err_n     = 1'b0;
    if (abort && (state != IDLE)) begin
      state_n   = IDLE;
      ad_cnt_n  = 4'd0;
      msg_cnt_n = 4'd0;
      round_n   = 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (legal) begin
              state_n   = LOAD;
              decrypt_n = operation_mode[0];
              ad_cnt_n  = num_ad_blocks;
              msg_cnt_n = num_msg_blocks;
            end else begin
              err_n = 1'b1;
            end
          end
        end
        LOAD: begin
          state_n = INIT_P;
          round_n = PA_FIRST;
        end
        INIT_P: begin
          if (round_idx == LAST_ROUND) begin
            state_n = INIT_K;
            round_n = 4'd0;
          end else begin
            round_n = round_idx + 4'd1;
          end
        end
        INIT_K: state_n = (ad_cnt != 4'd0) ? AD_WAIT : DSEP;
        AD_WAIT: begin
          if (absorb_en) begin
            state_n  = AD_P;
            ad_cnt_n = ad_cnt - 4'd1;
            round_n  = PB_FIRST;
          end
        end
        AD_P: begin
          if (round_idx == LAST_ROUND) begin
            state_n = (ad_cnt != 4'd0) ? AD_WAIT : DSEP;
            round_n = 4'd0;
          end else begin
            round_n = round_idx + 4'd1;
          end
        end
        DSEP: state_n = MSG_WAIT;
        // The final message block goes straight to finalization, no PB round.
        MSG_WAIT: begin
          if (absorb_en) begin
            msg_cnt_n = msg_cnt - 4'd1;
            if (msg_cnt == 4'd1) begin
              state_n = FIN_K;
            end else begin
              state_n = MSG_P;
              round_n = PB_FIRST;
            end
          end
        end
        MSG_P: begin
          if (round_idx == LAST_ROUND) begin
            state_n = MSG_WAIT;
            round_n = 4'd0;
          end else begin
            round_n = round_idx + 4'd1;
          end
        end
        FIN_K: begin
          state_n = FIN_P;
          round_n = PA_FIRST;
        end
        FIN_P: begin
          if (round_idx == LAST_ROUND) begin
            state_n = TAG;
            round_n = 4'd0;
          end else begin
            round_n = round_idx + 4'd1;
          end
        end
        TAG:     state_n = DONE;
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
    if (state_n == IDLE) begin
      decrypt_n = 1'b0;
    end
  end

  // Strobes are registered from the next state so they line up with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ad_cnt     <= 4'd0;
      msg_cnt    <= 4'd0;
      round_idx  <= 4'd0;
      decrypt    <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      state_load <= 1'b0;
      perm_en    <= 1'b0;
      key_xor    <= 1'b0;
      blk_req    <= 1'b0;
      blk_sel    <= 1'b0;
      last_blk   <= 1'b0;
      dom_sep    <= 1'b0;
      tag_en     <= 1'b0;
    end else begin
      state      <= state_n;
      ad_cnt     <= ad_cnt_n;
      msg_cnt    <= msg_cnt_n;
      round_idx  <= round_n;
      decrypt    <= decrypt_n;
      err        <= err_n;
      busy       <= (state_n != IDLE);
      done       <= (state_n == DONE);
      state_load <= (state_n == LOAD);
      perm_en    <= (state_n == INIT_P) || (state_n == AD_P) ||
                    (state_n == MSG_P)  || (state_n == FIN_P);
      key_xor    <= (state_n == INIT_K) || (state_n == FIN_K) || (state_n == TAG);
      blk_req    <= (state_n == AD_WAIT) || (state_n == MSG_WAIT);
      blk_sel    <= (state_n == MSG_WAIT);
      last_blk   <= ((state_n == AD_WAIT) && (ad_cnt_n == 4'd1)) ||
                    ((state_n == MSG_WAIT) && (msg_cnt_n == 4'd1));
      dom_sep    <= (state_n == DSEP);
      tag_en     <= (state_n == TAG);
    end
  end

endmodule

// File: tb/tb_ascon_round_sequencer.sv
// Directed bench for ascon_round_sequencer: table of operations plus abort,
// reset and reduced-round corner sequences.
module tb_ascon_round_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] operation_mode;
  logic [3:0] num_ad_blocks;
  logic [3:0] num_msg_blocks;
  logic       abort;
  logic       blk_ack;
  logic       busy, done, err, decrypt, state_load, perm_en;
  logic [3:0] round_idx;
  logic       key_xor, blk_req, blk_sel, absorb_en, last_blk, dom_sep, tag_en;

  logic       start_s;
  logic [2:0] mode_s;
  logic [3:0] ad_s, msg_s;
  logic       abort_s, ack_s;
  logic       busy_s, done_s, err_s, decrypt_s, state_load_s, perm_en_s;
  logic [3:0] round_idx_s;
  logic       key_xor_s, blk_req_s, blk_sel_s, absorb_en_s, last_blk_s, dom_sep_s, tag_en_s;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ascon_round_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .operation_mode(operation_mode),
    .num_ad_blocks(num_ad_blocks), .num_msg_blocks(num_msg_blocks),
    .abort(abort), .blk_ack(blk_ack), .busy(busy), .done(done), .err(err),
    .decrypt(decrypt), .state_load(state_load), .perm_en(perm_en),
    .round_idx(round_idx), .key_xor(key_xor), .blk_req(blk_req),
    .blk_sel(blk_sel), .absorb_en(absorb_en), .last_blk(last_blk),
    .dom_sep(dom_sep), .tag_en(tag_en)
  );

  ascon_round_sequencer #(.PA_ROUNDS(6), .PB_ROUNDS(6)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .operation_mode(mode_s),
    .num_ad_blocks(ad_s), .num_msg_blocks(msg_s),
    .abort(abort_s), .blk_ack(ack_s), .busy(busy_s), .done(done_s), .err(err_s),
    .decrypt(decrypt_s), .state_load(state_load_s), .perm_en(perm_en_s),
    .round_idx(round_idx_s), .key_xor(key_xor_s), .blk_req(blk_req_s),
    .blk_sel(blk_sel_s), .absorb_en(absorb_en_s), .last_blk(last_blk_s),
    .dom_sep(dom_sep_s), .tag_en(tag_en_s)
  );

  typedef struct {
    logic [2:0] mode;
    int         ad;
    int         msg;
    int         dly;
    bit         exp_err;
    int         exp_done_cyc;
    int         exp_perm;
    int         exp_absorb;
    int         exp_last;
    int         exp_pb_bursts;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic string nm(input int i, input string s);
    return $sformatf("v%0d_%s", i, s);
  endfunction

  function automatic int outs_main();
    return int'({busy, done, err, decrypt, state_load, perm_en, round_idx,
                 key_xor, blk_req, blk_sel, absorb_en, last_blk, dom_sep, tag_en});
  endfunction

  function automatic int outs_small();
    return int'({busy_s, done_s, err_s, decrypt_s, state_load_s, perm_en_s, round_idx_s,
                 key_xor_s, blk_req_s, blk_sel_s, absorb_en_s, last_blk_s, dom_sep_s, tag_en_s});
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int err_cnt = 0, err_at = 0, done_cnt = 0, done_at = 0, perm_cnt = 0;
    int absorb_cnt = 0, last_cnt = 0, bursts = 0, ridx_bad = 0, excl_bad = 0;
    int dec_bad = 0, wait_cnt = 0, nstrobe;
    bit busy_seen = 0, prev_perm = 0, finished = 0;
    logic [3:0] prev_ridx = 4'd0;
    @(negedge clk);
    operation_mode = v.mode;
    num_ad_blocks  = 4'(v.ad);
    num_msg_blocks = 4'(v.msg);
    blk_ack        = 1'b0;
    start          = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin done_cnt++; done_at = c; end
      if (err) begin err_cnt++; err_at = c; end
      if (busy) begin
        busy_seen = 1;
        if (decrypt != v.mode[0]) dec_bad++;
      end
      if (perm_en) begin
        perm_cnt++;
        if (!prev_perm && round_idx == 4'd4) bursts++;
        if (prev_perm && round_idx != prev_ridx + 4'd1) ridx_bad++;
      end else if (prev_perm && prev_ridx != 4'd11) begin
        ridx_bad++;
      end
      nstrobe = int'(perm_en) + int'(state_load) + int'(key_xor) +
                int'(dom_sep) + int'(tag_en) + int'(blk_req);
      if (nstrobe > 1 && !(nstrobe == 2 && key_xor && tag_en)) excl_bad++;
      prev_perm = perm_en;
      prev_ridx = round_idx;
      if (blk_req) begin
        blk_ack = (wait_cnt == v.dly);
        wait_cnt++;
      end else begin
        blk_ack  = 1'b0;
        wait_cnt = 0;
      end
      #1;
      if (absorb_en != (blk_req && blk_ack)) excl_bad++;
      if (absorb_en) begin
        absorb_cnt++;
        if (last_blk) last_cnt++;
      end
      if (c > 2 && !busy) begin
        finished = 1;
        break;
      end
    end
    blk_ack = 1'b0;
    check(nm(idx, "returned_idle"), int'(finished), 1);
    check(nm(idx, "err_pulses"), err_cnt, int'(v.exp_err));
    check(nm(idx, "busy_seen"), int'(busy_seen), int'(!v.exp_err));
    check(nm(idx, "done_pulses"), done_cnt, v.exp_err ? 0 : 1);
    if (v.exp_err) check(nm(idx, "err_cycle"), err_at, 1);
    else check(nm(idx, "done_cycle"), done_at, v.exp_done_cyc);
    check(nm(idx, "perm_cycles"), perm_cnt, v.exp_perm);
    check(nm(idx, "absorbs"), absorb_cnt, v.exp_absorb);
    check(nm(idx, "last_absorbs"), last_cnt, v.exp_last);
    check(nm(idx, "pb_bursts"), bursts, v.exp_pb_bursts);
    check(nm(idx, "round_seq_errs"), ridx_bad, 0);
    check(nm(idx, "exclusivity_errs"), excl_bad, 0);
    check(nm(idx, "decrypt_errs"), dec_bad, 0);
  endtask

  initial begin
    int hit, seen, cnt, n6, bad6, done6_at;
    bit fin6;
    vecs[0] = '{3'd0, 0,  1,  0, 1'b0, 31,  24,  1,  1, 0};
    vecs[1] = '{3'd1, 2,  3,  5, 1'b0, 92,  56,  5,  2, 4};
    vecs[2] = '{3'd0, 1,  2,  1, 1'b0, 52,  40,  3,  2, 2};
    vecs[3] = '{3'd0, 15, 15, 0, 1'b0, 292, 256, 30, 2, 29};
    vecs[4] = '{3'd1, 0,  15, 2, 1'b0, 187, 136, 15, 1, 14};
    vecs[5] = '{3'd5, 1,  1,  0, 1'b1, 0,   0,   0,  0, 0};
    vecs[6] = '{3'd0, 0,  0,  0, 1'b1, 0,   0,   0,  0, 0};
    vecs[7] = '{3'd2, 3,  4,  0, 1'b1, 0,   0,   0,  0, 0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; blk_ack = 1'b0;
    operation_mode = 3'd0; num_ad_blocks = 4'd0; num_msg_blocks = 4'd0;
    start_s = 1'b0; mode_s = 3'd0; ad_s = 4'd1; msg_s = 4'd1; abort_s = 1'b0; ack_s = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs_main(), 0);
    check("reset_outputs_small", outs_small(), 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Abort in IDLE is ignored; abort in LOAD returns to IDLE.
    @(negedge clk);
    operation_mode = 3'd0; num_ad_blocks = 4'd0; num_msg_blocks = 4'd1;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("idle_abort_ignored", int'(state_load), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_in_load", outs_main(), 0);

    // Abort during the third round of an AD permutation.
    operation_mode = 3'd0; num_ad_blocks = 4'd2; num_msg_blocks = 4'd1;
    blk_ack = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 0; seen = 0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (absorb_en) seen = 1;
      @(negedge clk);
      if (seen && perm_en && round_idx == 4'd6) begin hit = 1; break; end
    end
    check("abort_reached_ad_round3", hit, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; blk_ack = 1'b0;
    check("abort_ad_outputs", outs_main(), 0);
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    check("abort_quiet_after", cnt, 0);
    run_vec(8, vecs[0]);

    // Abort coinciding with blk_ack: absorb_en still follows the AND.
    @(negedge clk);
    operation_mode = 3'd0; num_ad_blocks = 4'd1; num_msg_blocks = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 0;
    for (int c = 0; c < 40; c++) begin
      if (blk_req) begin hit = 1; break; end
      @(negedge clk);
    end
    check("ack_abort_reached_wait", hit, 1);
    abort = 1'b1; blk_ack = 1'b1;
    #1;
    check("ack_abort_absorb_en", int'(absorb_en), 1);
    @(negedge clk);
    abort = 1'b0; blk_ack = 1'b0;
    check("ack_abort_idle", int'({busy, perm_en, done, blk_req}), 0);

    // Start while busy is ignored; reset in FIN_P clears everything.
    @(negedge clk);
    operation_mode = 3'd0; num_ad_blocks = 4'd0; num_msg_blocks = 4'd1;
    blk_ack = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 0; seen = 0; cnt = 0;
    for (int c = 1; c < 100; c++) begin
      if (c == 4) begin
        operation_mode = 3'd5; num_msg_blocks = 4'd0; start = 1'b1;
      end else if (c == 5) begin
        start = 1'b1; operation_mode = 3'd0; num_msg_blocks = 4'd1;
      end else begin
        start = 1'b0;
      end
      #1;
      if (absorb_en) seen = 1;
      @(negedge clk);
      if (err || state_load) cnt++;
      if (seen && perm_en) begin hit = 1; break; end
    end
    start = 1'b0;
    check("rst_reached_fin_p", hit, 1);
    check("busy_start_ignored", cnt, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; blk_ack = 1'b0;
    check("rst_fin_p_outputs", outs_main(), 0);
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    check("rst_quiet_after", cnt, 0);
    run_vec(9, vecs[2]);

    // Reduced-round instance: 1 AD, 1 msg, ack held high.
    @(negedge clk);
    start_s = 1'b1;
    n6 = 0; bad6 = 0; done6_at = 0; fin6 = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      start_s = 1'b0;
      if (perm_en_s) begin
        if (round_idx_s != 4'(6 + (n6 % 6))) bad6++;
        n6++;
      end
      if (done_s) done6_at = c;
      if (c > 2 && !busy_s) begin fin6 = 1; break; end
    end
    check("small_returned_idle", int'(fin6), 1);
    check("small_perm_cycles", n6, 18);
    check("small_round_seq_errs", bad6, 0);
    check("small_done_cycle", done6_at, 26);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
